// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM encoding for the binary-to-BCD converter
package bcd_pkg;
  localparam int DIGITS = 4;
  localparam int BCD_W = 4;
  localparam int MAX_VAL = 9999;
  localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble adjust cell, adds 3 to a BCD digit that is 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with saturation
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_LIMIT = MAX_VAL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [BCD_W-1:0]     digit3,
  output logic [BCD_W-1:0]     digit2,
  output logic [BCD_W-1:0]     digit1,
  output logic [BCD_W-1:0]     digit0
);
  localparam int W = BIN_WIDTH + DIGITS * BCD_W;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH-1:0] LIMIT = BIN_WIDTH'(MAX_LIMIT);
  state_t state, next;
  logic [W-1:0] work;
  logic [DIGITS*BCD_W-1:0] adj;
  logic [CW-1:0] cnt;
  logic sat, accept;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (.d(work[BIN_WIDTH+g*BCD_W +: BCD_W]), .q(adj[g*BCD_W +: BCD_W]));
  end
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign accept = start && !busy;
  always_comb begin
    next = accept ? SHIFT : (busy && cnt != '0) ? SHIFT : busy ? DONE : IDLE;
  end
  // the counter-zero cycle in SHIFT publishes the result, so DONE holds no datapath work
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work <= '0;
      cnt <= '0;
      sat <= 1'b0;
      overflow <= 1'b0;
      {digit3, digit2, digit1, digit0} <= '0;
    end else begin
      state <= next;
      if (accept) begin
        work <= W'(bin_in);
        sat <= bin_in > LIMIT;
        cnt <= CW'(BIN_WIDTH);
      end else if (busy && cnt != '0) begin
        work <= {adj, work[BIN_WIDTH-1:0]} << 1;
        cnt <= cnt - 1'b1;
      end else if (busy) begin
        overflow <= sat;
        {digit3, digit2, digit1, digit0} <= sat ? {DIGITS{SAT_DIGIT}} : work[W-1:BIN_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [13:0] bin_in = '0;
  logic busy, done, overflow;
  logic [3:0] digit3, digit2, digit1, digit0;
  int cmp = 0, errs = 0;
  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy), .done(done),
    .overflow(overflow), .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input string tag, input int start_lat);
    int lat = start_lat;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 15);
  endtask
  task automatic convert(input string tag, input logic [13:0] v, input logic [15:0] exp_d, input logic exp_o);
    start = 1'b1;
    bin_in = v;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(tag, 0);
    check({tag, "_digits"}, {digit3, digit2, digit1, digit0}, exp_d);
    check({tag, "_ovf"}, overflow, exp_o);
    check({tag, "_busy_at_done"}, busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
  endtask
  task automatic count_dones(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      n += int'(done);
    end
    check({tag, "_no_done"}, n, 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovf", overflow, 0);
    convert("c1234", 14'd1234, 16'h1234, 1'b0);
    convert("c0", 14'd0, 16'h0000, 1'b0);
    convert("c9999", 14'd9999, 16'h9999, 1'b0);
    convert("c10000", 14'd10000, 16'h9999, 1'b1);
    convert("c16383", 14'd16383, 16'h9999, 1'b1);
    start = 1'b1;
    bin_in = 14'd1234;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1;
    bin_in = 14'd42;
    tick();
    start = 1'b0;
    bin_in = 14'd77;
    check("ign_hold_digits", {digit3, digit2, digit1, digit0}, 16'h9999);
    check("ign_hold_ovf", overflow, 1);
    check("ign_busy", busy, 1);
    wait_done("ign", 5);
    check("ign_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
    check("ign_ovf", overflow, 0);
    count_dones("ign", 20);
    start = 1'b1;
    bin_in = 14'd507;
    tick();
    wait_done("b2b_first", 0);
    check("b2b_first_digits", {digit3, digit2, digit1, digit0}, 16'h0507);
    bin_in = 14'd89;
    tick();
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    check("b2b_hold_digits", {digit3, digit2, digit1, digit0}, 16'h0507);
    wait_done("b2b_second", 0);
    check("b2b_second_digits", {digit3, digit2, digit1, digit0}, 16'h0089);
    tick();
    convert("pre_ovf", 14'd12000, 16'h9999, 1'b1);
    start = 1'b1;
    bin_in = 14'd4321;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("rst_mid_ovf", overflow, 0);
    count_dones("rst_mid", 20);
    check("rst_mid_digits_after", {digit3, digit2, digit1, digit0}, 16'h0000);
    convert("c4321", 14'd4321, 16'h4321, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one shift per clock. It produces the four BCD digits (digit3..digit0) consumed by the display digit multiplexer and 7-segment scan path. It sits between the Pmod ALS SPI sample capture and the display path. Digit outputs hold their last converted value between conversions, so the display never shows partial results.

Parameters:
BIN_WIDTH, 14, width of binary input; 14 bits covers 0..16383
DIGITS, 4, number of BCD digits produced; fixed at 4 for the current display, ports sized to match
MAX_VAL, 9999, saturation ceiling; equals 10^DIGITS-1

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request conversion of bin_in; sampled only when busy=0
bin_in  input  BIN_WIDTH  unsigned binary value, captured on accepted start
busy  output  1  conversion in progress; start ignored while high
done  output  1  one-cycle pulse; digits/overflow updated in the same cycle
overflow  output  1  bin_in exceeded MAX_VAL; digits saturated to 9999
digit3  output  4  BCD thousands
digit2  output  4  BCD hundreds
digit1  output  4  BCD tens
digit0  output  4  BCD units

Behaviour:
- Reset: state=IDLE; busy=0, done=0, overflow=0, digit3..digit0=0; shift counter=0. Reset overrides everything, including mid-conversion; the partial result is discarded and outputs are not updated.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge N -> capture bin_in into the low bits of a working register (BIN_WIDTH + 4*DIGITS bits, BCD field cleared). Also capture sat = (bin_in > MAX_VAL). Load counter=BIN_WIDTH and go to SHIFT. busy=1 from edge N.
- SHIFT: on each edge, first add 3 to every 4-bit BCD field that is >= 5, then shift the whole register left by 1 and decrement counter. After the shift at which the counter reaches 0 (edge N+BIN_WIDTH), go to DONE.
- DONE entry (edge N+BIN_WIDTH+1): load digit outputs from the BCD field, or 9,9,9,9 if sat. Load overflow=sat. done=1 for exactly this cycle. busy=0.
- Latency: start sampled at edge N -> done high in the cycle following edge N+BIN_WIDTH+1, which is 15 cycles for default parameters.
- DONE: one cycle only. Then go to IDLE, or accept a new start in the same cycle (busy=0) and go directly to SHIFT. This supports back-to-back conversions with no idle gap.
- start while busy=1 is ignored and not queued; bin_in changes while busy have no effect.
- Outputs change only at DONE entry or reset. overflow is sticky until the next DONE entry.
- Shift counter width: $clog2(BIN_WIDTH+1).
- Add-3 adjust is applied before the shift and never after the final shift.

Decomposition:
- Shared package bcd_pkg: DIGITS, BCD_W=4, MAX_VAL, FSM state encoding (IDLE/SHIFT/DONE as 2-bit localparams), and the saturation pattern 4'd9.
- One natural sub-module: bcd_add3, a combinational 4-bit "if >=5 add 3" cell. It is instantiated DIGITS times inside the SHIFT datapath.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no start -> digits 0,0,0,0, busy=0, done=0, overflow=0.
- Single conversion: bin_in=1234, start pulse at edge N -> busy=1 from N; done pulse after edge N+15; digits 1,2,3,4; overflow=0.
- Boundaries: bin_in=0 -> 0,0,0,0. bin_in=9999 -> 9,9,9,9 with overflow=0. bin_in=10000 -> 9,9,9,9 with overflow=1. bin_in=16383 -> 9,9,9,9 with overflow=1.
- Ignored start: start 1234, then start again 5 cycles later with bin_in=42 -> single done, digits 1,2,3,4. Outputs hold their previous values until done.
- Back-to-back: hold start=1 continuously with bin_in=0507 then 0089 presented in the DONE cycle -> done pulses 15 cycles apart. Results are 0,5,0,7 then 0,0,8,9.
- Reset mid-operation: start 4321, assert rst at cycle 7 -> no done pulse, digits 0,0,0,0, busy=0. A subsequent start of 4321 converts correctly.
